inertial_integrator: RTL and testbench

INERTIAL_INTEGRATOR -- requirements
Module: inertial_integrator

---
 rtl/inertial_integrator.sv | 84 ++++++++
 tb/tb_inertial_integrator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/inertial_integrator.sv
// inertial_integrator: calibrates the pitch-rate offset, then fuses the
// offset-compensated rate with the Z-accel pitch estimate into a pitch integrator.
module inertial_integrator #(
  parameter int CAL_LOG2 = 8,
  parameter logic signed [15:0] AZ_OFFSET = 16'sh00A0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] ptch_rt,
  input  logic signed [15:0] AZ,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt_comp,
  output logic               ptch_vld,
  output logic               cal_done
);
  typedef enum logic {CAL = 1'b0, RUN = 1'b1} state_e;
  state_e state_q, state_d;
  logic [CAL_LOG2-1:0] cnt_q, cnt_d;
  logic signed [23:0] sum_q, sum_d, sum_nx;
  logic signed [15:0] off_q, off_d, comp_q, comp_d, comp_nx, az_comp, acc;
  logic signed [26:0] int_q, int_d;
  logic signed [16:0] rt_diff, az_diff;
  logic signed [25:0] az_ext, prod;
  logic signed [27:0] int_ext, comp_ext, fusion, int_nx;
  logic vld_q, cal_last, cal_upd, run_upd;
  function automatic logic signed [15:0] sat17(input logic signed [16:0] v);
    return (v[16] != v[15]) ? (v[16] ? 16'sh8000 : 16'sh7FFF) : v[15:0];
  endfunction
  function automatic logic signed [26:0] sat28(input logic signed [27:0] v);
    return (v[27] != v[26]) ? (v[27] ? 27'sh4000000 : 27'sh3FFFFFF) : v[26:0];
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= CAL;
    else state_q <= state_d;
  always_comb begin
    cal_upd = (state_q == CAL) && vld;
    cal_last = cal_upd && (&cnt_q);
    state_d = cal_last ? RUN : state_q;
  end
  always_comb begin
    cal_done = state_q == RUN;
    run_upd = cal_done && vld;
    ptch = int_q[26:11];
    ptch_rt_comp = comp_q;
    ptch_vld = vld_q;
  end
  always_comb begin
    sum_nx = sum_q + {{8{ptch_rt[15]}}, ptch_rt};
    sum_d = cal_upd ? sum_nx : sum_q;
    cnt_d = cal_upd ? cnt_q + 1'b1 : cnt_q;
    off_d = cal_last ? 16'(sum_nx >>> CAL_LOG2) : off_q;
    rt_diff = {ptch_rt[15], ptch_rt} - {off_q[15], off_q};
    az_diff = {AZ[15], AZ} - {AZ_OFFSET[15], AZ_OFFSET};
    comp_nx = sat17(rt_diff);
    az_comp = sat17(az_diff);
    az_ext = az_comp;
    prod = az_ext * 26'sd327;
    acc = 16'(prod >>> 13);
    // fusion nudges the integrator toward the accel estimate using the registered pitch
    fusion = (acc > ptch) ? 28'sd1024 : -28'sd1024;
    int_ext = int_q;
    comp_ext = comp_nx;
    int_nx = int_ext - comp_ext + fusion;
    comp_d = run_upd ? comp_nx : comp_q;
    int_d = run_upd ? sat28(int_nx) : int_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      sum_q <= '0;
      off_q <= '0;
      comp_q <= '0;
      int_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      off_q <= off_d;
      comp_q <= comp_d;
      int_q <= int_d;
      vld_q <= run_upd;
    end
endmodule

// File: tb/tb_inertial_integrator.sv
// tb_inertial_integrator: randomized scoreboard bench with an integer reference model.
module tb_inertial_integrator;
  localparam int CL = 2;
  logic clk = 0, rst_n = 0, vld = 0;
  logic [15:0] ptch_rt = 0, AZ = 0;
  logic [15:0] ptch, ptch_rt_comp;
  logic ptch_vld, cal_done;
  inertial_integrator #(.CAL_LOG2(CL), .AZ_OFFSET(16'sh00A0)) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ),
    .ptch(ptch), .ptch_rt_comp(ptch_rt_comp), .ptch_vld(ptch_vld), .cal_done(cal_done)
  );
  always #5 clk = ~clk;
  typedef struct {logic [15:0] p; logic [15:0] c;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, seen = 0;
  bit m_run;
  int m_n, m_sum, m_off, m_int;
  logic [15:0] last_p = 0, last_c = 0;
  function automatic int clamp(int v, int lo, int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, x);
    end
  endtask
  task automatic model_reset;
    m_run = 0; m_n = 0; m_sum = 0; m_off = 0; m_int = 0;
    q.delete();
  endtask
  task automatic model(int rt, int az);
    if (!m_run) begin
      m_sum += rt;
      m_n++;
      if (m_n == (1 << CL)) begin
        m_off = m_sum >>> CL;
        m_run = 1;
      end
    end else begin
      int c, a, acc, f;
      c = clamp(rt - m_off, -32768, 32767);
      a = clamp(az - 160, -32768, 32767);
      acc = (a * 327) >>> 13;
      f = (acc > (m_int >>> 11)) ? 1024 : -1024;
      m_int = clamp(m_int - c + f, -(1 << 26), (1 << 26) - 1);
      q.push_back('{16'(m_int >>> 11), 16'(c)});
    end
  endtask
  task automatic send(logic [15:0] rt, logic [15:0] az);
    int rs, as;
    @(negedge clk);
    vld = 1; ptch_rt = rt; AZ = az;
    rs = int'($signed(rt));
    as = int'($signed(az));
    model(rs, as);
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      vld = 0; ptch_rt = 16'($urandom); AZ = 16'($urandom);
    end
  endtask
  task automatic do_reset;
    @(posedge clk);
    #3 rst_n = 0;
    vld = 0;
    model_reset();
    #1;
    chk("rst_cal_done", cal_done, 0);
    chk("rst_ptch", ptch, 0);
    chk("rst_ptch_vld", ptch_vld, 0);
    chk("rst_comp", ptch_rt_comp, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic calibrate;
    send(16'h0010, 16'($urandom));
    send(16'h0014, 16'($urandom));
    send(16'h000C, 16'($urandom));
    @(posedge clk); #1 chk("cal_done_early", cal_done, 0);
    send(16'h0010, 16'($urandom));
    @(posedge clk); #1;
    chk("cal_done_rise", cal_done, 1);
    chk("cal_ptch", ptch, 0);
    chk("cal_comp", ptch_rt_comp, 0);
    chk("cal_no_vld", ptch_vld, 0);
    idle(1);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      last_p = ptch; last_c = ptch_rt_comp;
    end else begin
      if (ptch_vld) begin
        seen++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ptch_vld got 1 want 0");
        end else begin
          e = q.pop_front();
          chk("ptch", ptch, e.p);
          chk("ptch_rt_comp", ptch_rt_comp, e.c);
        end
      end else begin
        chk("hold_ptch", ptch, last_p);
        chk("hold_comp", ptch_rt_comp, last_c);
      end
      last_p = ptch; last_c = ptch_rt_comp;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("init_ptch", ptch, 0);
    chk("init_comp", ptch_rt_comp, 0);
    chk("init_vld", ptch_vld, 0);
    chk("init_cal_done", cal_done, 0);
    rst_n = 1;
    calibrate();
    idle(2);
    send(16'h0010, 16'h00A0); idle(1);
    send(16'h0010, 16'h00A0); idle(2);
    chk("fusion_comp", ptch_rt_comp, 16'h0000);
    do_reset();
    calibrate();
    repeat (16) send(16'h0810, 16'h00A0);
    idle(2);
    chk("rate_comp", ptch_rt_comp, 16'h0800);
    chk("rate_ptch", ptch, 16'hFFF7);
    send(16'h8000, 16'($urandom)); idle(2);
    chk("sat_comp", ptch_rt_comp, 16'h8000);
    seen = 0;
    repeat (5) send(16'($urandom_range(0, 4095)), 16'($urandom));
    idle(4);
    chk("b2b_count", seen, 5);
    repeat (2200) send(16'h8000, 16'h00A0);
    idle(1);
    chk("int_sat_pos", ptch, 16'h7FFF);
    repeat (4400) send(16'h7FFF, 16'h00A0);
    idle(1);
    chk("int_sat_neg", ptch, 16'h8000);
    repeat (300) begin
      send(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    send(16'h0400, 16'h7000);
    do_reset();
    calibrate();
    repeat (50) begin
      send(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(3);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
